seq_restoring_divider: RTL
==========================

Name: seq_restoring_divider

Overview:
Sequential restoring divider. It is the inverse operation of the team's 4x4 Braun array multiplier: it takes an 8-bit product-width dividend and a 4-bit divisor and returns the quotient and remainder. It resolves one quotient bit per clock under a start/done handshake, and it is the divide path beside the combinational multiplier in the arithmetic block set.

Parameters:
DW, 8, dividend and quotient width (matches the multiplier product width)
VW, 4, divisor and remainder width (matches the multiplier operand width)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
start  input  1  request; sampled only while busy=0
dividend  input  DW  unsigned dividend; sampled with start
divisor  input  VW  unsigned divisor; sampled with start
busy  output  1  division in progress
done  output  1  one-cycle pulse; results valid
quotient  output  DW  unsigned quotient; held until next accepted start
remainder  output  VW  unsigned remainder; held until next accepted start
div_by_zero  output  1  last accepted request had divisor==0; held with results

Behaviour:
- Reset: clk and rst are the only clock and reset. rst is asynchronous and active-high, with no synchronous reset path.
- While rst is asserted: state=IDLE; busy, done, quotient, remainder and div_by_zero are all 0; internal iteration counter = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE or DONE with start=1 and divisor!=0, sampled at edge k:
  - Latch dividend into a shift register and divisor into a register.
  - Clear the partial remainder (VW+1 bits) and set the counter to DW-1.
  - Clear div_by_zero; go to RUN; busy=1 from edge k.
- RUN, one step per cycle, MSB first:
  - pr = {pr[VW-1:0], dvd_msb}; shift dividend left.
  - If pr >= {0, divisor}: pr -= divisor and shift in quotient bit 1; otherwise shift in 0.
  - Counter decrements each step; after the step with counter==0, go to DONE.
  - DW RUN cycles in total.
- DONE entry (edge k+DW):
  - quotient = accumulated bits; remainder = pr[VW-1:0].
  - busy falls and done rises at edge k+DW; done falls at edge k+DW+1.
  - Start-to-done latency is exactly DW cycles.
- DONE with no start -> IDLE. Results and div_by_zero are held in IDLE.
- Divide by zero (start with divisor==0 while busy=0, at edge k):
  - Go directly to DONE at edge k; busy never asserts.
  - quotient = all ones; remainder = 0; div_by_zero = 1; done pulses for the cycle after edge k.
- start while busy=1 is ignored: operands are not resampled and the current division completes unaffected.
- start during the done cycle (state DONE) is accepted. A new RUN begins, done drops next edge, and outputs keep their old values until the new DONE.
- quotient and remainder change only on entry to DONE, never mid-RUN.
- Invariant (unsigned): dividend == quotient*divisor + remainder, and remainder < divisor.
- rst asserted mid-RUN aborts immediately: all outputs go to 0; no done is produced for the aborted request.
- Edge values:
  - dividend=0 -> q=0, r=0.
  - divisor=1 -> q=dividend, r=0.
  - dividend < divisor -> q=0, r=dividend[VW-1:0].

Optional Feature:
Macro DIV_SELFCHECK_EN.
- Defined:
  - Adds output check_err (1 bit). It is reset to 0 and updated on each DONE entry with divisor!=0.
  - check_err = 1 if quotient*divisor + remainder != latched dividend (DW+VW-bit compare), or if remainder >= divisor; otherwise 0.
  - check_err is forced to 0 on div-by-zero completions and is held until the next DONE entry.
- Not defined: check_err port and its logic are absent; all other behaviour is identical.

Test Plan:
1. Reset, then start dividend=10 (0x0A), divisor=5 -> busy 8 cycles; done exactly 8 cycles after start edge; q=2, r=0, div_by_zero=0.
2. dividend=60 (0x3C), divisor=10 -> q=6, r=0. Then dividend=200, divisor=7 -> q=28, r=4. Back-to-back with start in the done cycle: second done 8 cycles after the first.
3. Boundaries: 255/1 -> q=255, r=0; 3/15 -> q=0, r=3; 0/9 -> q=0, r=0; 255/15 -> q=17, r=0.
4. Divisor=0, dividend=0x55 -> done the next cycle, busy stays 0, q=0xFF, r=0, div_by_zero=1. A following 9/2 request -> q=4, r=1, div_by_zero=0.
5. Start 100/3, pulse start with 50/5 at cycle 3 of RUN -> ignored; done at cycle 8 with q=33, r=1.
6. Start 200/7, assert rst at cycle 4 of RUN -> all outputs 0 immediately, no done pulse. After release, 200/7 -> q=28, r=4. With DIV_SELFCHECK_EN defined, check_err stays 0 throughout all scenarios.

Source files
------------

// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider: unsigned DW-bit dividend by VW-bit divisor,
// one quotient bit per clock, MSB first, under a start/done handshake.
// Quotient bits are shifted into the vacated LSBs of the dividend register,
// so after DW steps that register holds the quotient.
// A zero divisor completes immediately with quotient all ones, remainder 0
// and div_by_zero set.
// Optional build macro DIV_SELFCHECK_EN adds check_err, which flags a
// completion where quotient*divisor+remainder differs from the dividend or
// where remainder >= divisor.
`timescale 1ns/1ps

module seq_restoring_divider #(
   parameter int DW = 8,
   parameter int VW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [DW-1:0] dividend,
   input  logic [VW-1:0] divisor,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] quotient,
   output logic [VW-1:0] remainder,
   output logic          div_by_zero
`ifdef DIV_SELFCHECK_EN
   ,
   output logic          check_err
`endif
);

   localparam int CW = (DW > 1) ? $clog2(DW) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state, state_nxt;
   logic [DW-1:0] dvd;        // dividend bits still to consume; quotient bits enter at the LSB
   logic [VW-1:0] dvs;
   logic [VW-1:0] pr;         // partial remainder; always < dvs between steps
   logic [CW-1:0] cnt;
   logic          accept;
   logic          zero_req;
   logic          last_step;
   logic [VW:0]   pr_shift;
   logic [VW-1:0] pr_step;
   logic          q_bit;
   logic [DW-1:0] q_final;

`ifdef DIV_SELFCHECK_EN
   logic [DW-1:0] dvd_keep;   // untouched copy of the accepted dividend

   // Returns 1 when the result pair does not reconstruct the dividend.
   function automatic logic check_fail(input logic [DW-1:0] q,
                                       input logic [VW-1:0] r,
                                       input logic [VW-1:0] d,
                                       input logic [DW-1:0] n);
      logic [DW+VW-1:0] recon;
      recon = (DW+VW)'(q) * (DW+VW)'(d) + (DW+VW)'(r);
      return (recon != (DW+VW)'(n)) || (r >= d);
   endfunction
`endif

   // A request is taken whenever no division is running.
   assign accept    = start && (state != RUN);
   assign zero_req  = (divisor == '0);
   assign last_step = (state == RUN) && (cnt == '0);
   assign busy      = (state == RUN);
   assign done      = (state == DONE);

   // One restoring step: shift in the next dividend bit, subtract if it fits.
   always_comb begin
      pr_shift = {pr, dvd[DW-1]};
      q_bit    = (pr_shift >= {1'b0, dvs});
      pr_step  = pr_shift[VW-1:0];
      if (q_bit) begin
         pr_step = VW'(pr_shift - {1'b0, dvs});
      end
      q_final  = {dvd[DW-2:0], q_bit};
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = zero_req ? DONE : RUN;
            end
         end
         RUN: begin
            if (cnt == '0) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            if (start) begin
               state_nxt = zero_req ? DONE : RUN;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Operand and partial-remainder datapath; contents only matter while running.
   always_ff @(posedge clk) begin
      if (accept && !zero_req) begin
         dvd <= dividend;
         dvs <= divisor;
         pr  <= '0;
      end else if (state == RUN) begin
         dvd <= q_final;
         pr  <= pr_step;
      end
   end

`ifdef DIV_SELFCHECK_EN
   // Keep the original dividend for the reconstruction check.
   always_ff @(posedge clk) begin
      if (accept && !zero_req) begin
         dvd_keep <= dividend;
      end
   end
`endif

   // Step counter and result registers; results change only on DONE entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt         <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         if (accept) begin
            div_by_zero <= zero_req;
            if (zero_req) begin
               quotient  <= '1;
               remainder <= '0;
            end else begin
               cnt <= CW'(DW-1);
            end
         end else if (state == RUN) begin
            cnt <= cnt - CW'(1);
            if (last_step) begin
               quotient  <= q_final;
               remainder <= pr_step;
            end
         end
      end
   end

`ifdef DIV_SELFCHECK_EN
   // Reconstruction check evaluated on every DONE entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         check_err <= 1'b0;
      end else if (accept && zero_req) begin
         check_err <= 1'b0;
      end else if (last_step) begin
         check_err <= check_fail(q_final, pr_step, dvs, dvd_keep);
      end
   end
`endif

endmodule
